// File: rtl/bram_b_streamer.sv
// Burst reader: fetches a run of consecutive words from a BRAM port and
// streams them out on a valid/ready interface through a small skid FIFO.
module bram_b_streamer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int DEPTH = RD_LAT + 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  sent_cnt;
  logic [ADDR_W-1:0] addr_q;

  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic [RD_LAT-1:0] rd_pipe;

  logic              pop;
  logic              capture;
  logic              can_issue;
  logic [OCC_W-1:0]  inflight;
  logic [OCC_W:0]    committed;

  // ---------------------------------------------------------------------------
  // Flow control: a read may only be launched if its word is guaranteed a FIFO
  // slot, counting words buffered, words still in the BRAM pipe, and the word
  // leaving this cycle.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + OCC_W'(rd_pipe[i]);
    end
  end

  assign m_valid   = (occ != '0);
  assign pop       = m_valid & m_ready;
  assign capture   = rd_pipe[RD_LAT-1];
  assign committed = {1'b0, occ} + {1'b0, inflight} - (OCC_W+1)'(pop);
  assign can_issue = (committed < (OCC_W+1)'(DEPTH));

  assign bram_en   = (state == ISSUE) && (issue_cnt != len_q) && can_issue;
  assign bram_we   = 1'b0;
  assign bram_addr = bram_en ? addr_q : '0;

  assign m_data    = m_valid ? fifo_mem[rd_ptr] : '0;
  assign m_last    = m_valid && (sent_cnt == len_q - CNT_W'(1));

  // ---------------------------------------------------------------------------
  // Burst control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order; later assignments win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      issue_cnt <= '0;
      sent_cnt  <= '0;
      addr_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pop) begin
        sent_cnt <= sent_cnt + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            addr_q    <= base_addr;
            issue_cnt <= '0;
            sent_cnt  <= '0;
            if (length == '0) begin
              len_q <= '0;
              state <= DONE;
              done  <= 1'b1;
            end else begin
              len_q <= (length > MAX_LEN) ? MAX_LEN : length;
              state <= ISSUE;
              busy  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (bram_en) begin
            addr_q    <= addr_q + ADDR_W'(1);
            issue_cnt <= issue_cnt + CNT_W'(1);
            if (issue_cnt == len_q - CNT_W'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // sent_cnt reaches len_q the cycle after the final handshake.
          if (sent_cnt == len_q) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read-return pipe and output FIFO control
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
    end else begin
      rd_pipe <= RD_LAT'({rd_pipe, bram_en});
      if (capture) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({capture, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // NOTE: the FIFO storage has no reset; emptiness is tracked by occ and
  // m_data is gated by m_valid, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (capture) begin
      fifo_mem[wr_ptr] <= bram_dout;
    end
  end

endmodule
